// File: rtl/sram_ctrl_if.sv
// Request/response, clear-control and SRAM pin bundle for sram_ctrl.
// slave is the controller's view; master is the requester/SRAM side.
interface sram_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_write;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_data;
    logic                  o_resp_valid;
    logic [DATA_WIDTH-1:0] o_resp_data;
    logic                  i_clear;
    logic                  o_busy;
    logic                  o_clear_done;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_write;
    logic [DATA_WIDTH-1:0] o_mem_data;
    logic [DATA_WIDTH-1:0] i_mem_data;

    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_clear, i_mem_data,
        output o_req_ready, o_resp_valid, o_resp_data, o_busy, o_clear_done,
               o_mem_addr, o_mem_write, o_mem_data
    );

    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_data, i_clear, i_mem_data,
        input  o_req_ready, o_resp_valid, o_resp_data, o_busy, o_clear_done,
               o_mem_addr, o_mem_write, o_mem_data
    );
endinterface

// File: rtl/sram_ctrl.sv
// Initiator-side controller for the single-port accelerator SRAM: request
// handshake, two-edge read pipeline and a zero-fill clear sequence.
module sram_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 16,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        i_clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CW-1:0]       LAST_K  = CW'(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [0:0] S_RST   = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [1:0]            rd_v_q, rd_v_d;
    logic [1:0]            rd_oor_q, rd_oor_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  done_q, done_d;

    logic req_ready_c;
    logic accept_c;
    logic in_range_c;
    logic clear_step_c;

    // Next-state, SRAM pin, read-pipeline and response logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_write_d  = 1'b0;
        mem_data_d   = mem_data_q;
        done_d       = 1'b0;
        clear_step_c = 1'b0;

        req_ready_c = (state_q == S_IDLE) && !bus.i_clear;
        accept_c    = bus.i_req_valid && req_ready_c;
        in_range_c  = {1'b0, bus.i_req_addr} < DEPTH_W;

        // Read tags shift every edge so in-flight reads survive a clear
        rd_v_d       = {rd_v_q[0], accept_c && !bus.i_req_write};
        rd_oor_d     = {rd_oor_q[0], !in_range_c};
        resp_valid_d = rd_v_q[1];
        resp_data_d  = resp_data_q;
        if (rd_v_q[1]) begin
            resp_data_d = rd_oor_q[1] ? '0 : bus.i_mem_data;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.i_clear) begin
                    state_d      = S_CLEAR;
                    clear_step_c = 1'b1;
                end else if (accept_c) begin
                    mem_addr_d  = bus.i_req_addr;
                    mem_write_d = bus.i_req_write && in_range_c;
                    if (bus.i_req_write) begin
                        mem_data_d = bus.i_req_data;
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST_K) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    clear_step_c = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // cnt_q holds the next location to present
        if (clear_step_c) begin
            mem_addr_d  = ADDR_WIDTH'(cnt_q);
            mem_write_d = 1'b1;
            mem_data_d  = '0;
            cnt_d       = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RST;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_write_q  <= 1'b0;
            mem_data_q   <= '0;
            rd_v_q       <= '0;
            rd_oor_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_write_q  <= mem_write_d;
            mem_data_q   <= mem_data_d;
            rd_v_q       <= rd_v_d;
            rd_oor_q     <= rd_oor_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            done_q       <= done_d;
        end
    end

    assign bus.o_req_ready  = req_ready_c;
    assign bus.o_busy       = (state_q == S_CLEAR);
    assign bus.o_clear_done = done_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_write  = mem_write_q;
    assign bus.o_mem_data   = mem_data_q;
    assign bus.o_resp_valid = resp_valid_q;
    assign bus.o_resp_data  = resp_data_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one DEPTH=16 auto-clear instance and one
// DEPTH=12 instance for out-of-range handling, each with an SRAM model.
module tb_sram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus16 ();
    sram_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus12 ();

    sram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1))
        u_dut16 (.i_clk(clk), .rst(rst), .bus(bus16));
    sram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .CLEAR_ON_RESET(1'b0))
        u_dut12 (.i_clk(clk), .rst(rst), .bus(bus12));

    // SRAM models: synchronous write, registered read of the presented address
    logic [31:0] mem16 [16];
    logic [31:0] mem12 [16];
    always @(posedge clk) begin
        if (bus16.o_mem_write) mem16[bus16.o_mem_addr] <= bus16.o_mem_data;
        bus16.i_mem_data <= mem16[bus16.o_mem_addr];
        if (bus12.o_mem_write) mem12[bus12.o_mem_addr] <= bus12.o_mem_data;
        bus12.i_mem_data <= mem12[bus12.o_mem_addr];
    end

    logic [31:0] rq16 [$];
    int          rc16 [$];
    logic [31:0] rq12 [$];
    int          rc12 [$];
    always @(negedge clk) begin
        if (bus16.o_resp_valid === 1'b1) begin rq16.push_back(bus16.o_resp_data); rc16.push_back(cyc); end
        if (bus12.o_resp_valid === 1'b1) begin rq12.push_back(bus12.o_resp_data); rc12.push_back(cyc); end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req16(input logic wr, input logic [3:0] a, input logic [31:0] d);
        bus16.i_req_valid = 1'b1; bus16.i_req_write = wr; bus16.i_req_addr = a; bus16.i_req_data = d;
        @(negedge clk);
    endtask

    task automatic req12(input logic wr, input logic [3:0] a, input logic [31:0] d);
        bus12.i_req_valid = 1'b1; bus12.i_req_write = wr; bus12.i_req_addr = a; bus12.i_req_data = d;
        @(negedge clk);
    endtask

    task automatic idle_all();
        bus16.i_req_valid = 1'b0; bus16.i_req_write = 1'b0;
        bus12.i_req_valid = 1'b0; bus12.i_req_write = 1'b0;
    endtask

    // Follows a DEPTH=16 clear to its done pulse, checking each zero-fill write
    task automatic watch_clear(output int nb, output int nw, output int nd);
        nb = 0; nw = 0; nd = 0;
        for (int i = 0; i < 40 && nd == 0; i++) begin
            @(negedge clk);
            if (bus16.o_busy) begin
                nb++;
                check("clr_ready", 32'(bus16.o_req_ready), 32'd0);
            end
            if (bus16.o_mem_write) begin
                check("clr_addr", 32'(bus16.o_mem_addr), 32'(nw));
                check("clr_data", bus16.o_mem_data, 32'd0);
                nw++;
            end
            if (bus16.o_clear_done) nd++;
        end
    endtask

    task automatic check_clear_run(input string tag);
        int nb, nw, nd;
        watch_clear(nb, nw, nd);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd16);
        check({tag, "_writes"}, 32'(nw), 32'd16);
        check({tag, "_done"}, 32'(nd), 32'd1);
        check({tag, "_ready_after"}, 32'(bus16.o_req_ready), 32'd1);
        check({tag, "_busy_after"}, 32'(bus16.o_busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus16.o_clear_done), 32'd0);
    endtask

    int  acc;
    bit  found;

    initial begin
        bus16.i_req_valid = 1'b0; bus16.i_req_write = 1'b0; bus16.i_req_addr = '0;
        bus16.i_req_data = '0; bus16.i_clear = 1'b0;
        bus12.i_req_valid = 1'b0; bus12.i_req_write = 1'b0; bus12.i_req_addr = '0;
        bus12.i_req_data = '0; bus12.i_clear = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_mem_addr", 32'(bus16.o_mem_addr), 32'd0);
        check("rst_mem_write", 32'(bus16.o_mem_write), 32'd0);
        check("rst_mem_data", bus16.o_mem_data, 32'd0);
        check("rst_resp_valid", 32'(bus16.o_resp_valid), 32'd0);
        check("rst_resp_data", bus16.o_resp_data, 32'd0);
        check("rst_clear_done", 32'(bus16.o_clear_done), 32'd0);
        check("rst_busy16", 32'(bus16.o_busy), 32'd1);
        check("rst_ready16", 32'(bus16.o_req_ready), 32'd0);
        check("rst_busy12", 32'(bus12.o_busy), 32'd0);
        check("rst_ready12", 32'(bus12.o_req_ready), 32'd1);

        // Auto-clear after reset release
        rst = 1'b0;
        check_clear_run("rstclr");

        // Write 0xDEADBEEF to addr 3 then read it on the next cycle
        req16(1'b1, 4'd3, 32'hDEADBEEF);
        check("wr_mem_write", 32'(bus16.o_mem_write), 32'd1);
        check("wr_mem_addr", 32'(bus16.o_mem_addr), 32'd3);
        check("wr_mem_data", bus16.o_mem_data, 32'hDEADBEEF);
        acc = cyc + 1;
        req16(1'b0, 4'd3, 32'd0);
        idle_all();
        repeat (4) @(negedge clk);
        check("wr_rd_count", 32'(rq16.size()), 32'd1);
        if (rq16.size() >= 1) begin
            check("wr_rd_data", rq16[0], 32'hDEADBEEF);
            check("wr_rd_latency", 32'(rc16[0] - acc), 32'd2);
        end
        rq16.delete(); rc16.delete();

        // Back-to-back reads of 1, 2, 3
        req16(1'b1, 4'd1, 32'h11);
        req16(1'b1, 4'd2, 32'h22);
        req16(1'b1, 4'd3, 32'h33);
        acc = cyc + 1;
        req16(1'b0, 4'd1, 32'd0);
        req16(1'b0, 4'd2, 32'd0);
        req16(1'b0, 4'd3, 32'd0);
        idle_all();
        repeat (5) @(negedge clk);
        check("b2b_count", 32'(rq16.size()), 32'd3);
        if (rq16.size() == 3) begin
            check("b2b_data0", rq16[0], 32'h11);
            check("b2b_data1", rq16[1], 32'h22);
            check("b2b_data2", rq16[2], 32'h33);
            check("b2b_cyc0", 32'(rc16[0] - acc), 32'd2);
            check("b2b_cyc1", 32'(rc16[1] - acc), 32'd3);
            check("b2b_cyc2", 32'(rc16[2] - acc), 32'd4);
        end
        rq16.delete(); rc16.delete();

        // Out-of-range handling on DEPTH=12
        bus12.i_clear = 1'b1;
        #1 check("oor_ready_clear", 32'(bus12.o_req_ready), 32'd0);
        bus12.i_clear = 1'b0;
        #1 check("oor_ready_idle", 32'(bus12.o_req_ready), 32'd1);
        req12(1'b1, 4'd5, 32'h5A5A5A5A);
        check("oor_wr5", 32'(bus12.o_mem_write), 32'd1);
        req12(1'b1, 4'd11, 32'hB11B11B1);
        check("oor_wr11", 32'(bus12.o_mem_write), 32'd1);
        check("oor_wr11_addr", 32'(bus12.o_mem_addr), 32'd11);
        req12(1'b1, 4'd12, 32'hC0C0C0C0);
        check("oor_wr12", 32'(bus12.o_mem_write), 32'd0);
        req12(1'b1, 4'd14, 32'hAAAAAAAA);
        check("oor_wr14", 32'(bus12.o_mem_write), 32'd0);
        acc = cyc + 1;
        req12(1'b0, 4'd14, 32'd0);
        req12(1'b0, 4'd5, 32'd0);
        req12(1'b0, 4'd11, 32'd0);
        req12(1'b0, 4'd12, 32'd0);
        idle_all();
        repeat (5) @(negedge clk);
        check("oor_rd_count", 32'(rq12.size()), 32'd4);
        if (rq12.size() == 4) begin
            check("oor_rd14", rq12[0], 32'd0);
            check("oor_rd5", rq12[1], 32'h5A5A5A5A);
            check("oor_rd11", rq12[2], 32'hB11B11B1);
            check("oor_rd12", rq12[3], 32'd0);
            check("oor_rd_latency", 32'(rc12[0] - acc), 32'd2);
        end

        // Read in flight across a clear keeps pre-clear data
        req16(1'b1, 4'd5, 32'h55);
        acc = cyc + 1;
        req16(1'b0, 4'd5, 32'd0);
        idle_all();
        bus16.i_clear = 1'b1;
        #1 check("clr_ready_comb", 32'(bus16.o_req_ready), 32'd0);
        @(posedge clk);
        #1 bus16.i_clear = 1'b0;
        check_clear_run("midclr");
        check("inflight_count", 32'(rq16.size()), 32'd1);
        if (rq16.size() >= 1) begin
            check("inflight_data", rq16[0], 32'h55);
            check("inflight_latency", 32'(rc16[0] - acc), 32'd2);
        end
        rq16.delete(); rc16.delete();
        req16(1'b0, 4'd5, 32'd0);
        req16(1'b1, 4'd9, 32'h99);
        req16(1'b0, 4'd9, 32'd0);
        idle_all();
        repeat (4) @(negedge clk);
        check("post_clr_count", 32'(rq16.size()), 32'd2);
        if (rq16.size() == 2) begin
            check("post_clr_rd5", rq16[0], 32'd0);
            check("post_clr_rd9", rq16[1], 32'h99);
        end
        rq16.delete(); rc16.delete();

        // Reset at clear step 7
        bus16.i_clear = 1'b1;
        @(posedge clk);
        #1 bus16.i_clear = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus16.o_mem_write && bus16.o_mem_addr == 4'd7) found = 1'b1;
        end
        check("k7_found", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_mem_addr", 32'(bus16.o_mem_addr), 32'd0);
        check("arst_mem_write", 32'(bus16.o_mem_write), 32'd0);
        check("arst_mem_data", bus16.o_mem_data, 32'd0);
        check("arst_resp_valid", 32'(bus16.o_resp_valid), 32'd0);
        check("arst_resp_data", bus16.o_resp_data, 32'd0);
        check("arst_busy", 32'(bus16.o_busy), 32'd1);
        check("arst_done", 32'(bus16.o_clear_done), 32'd0);
        check("arst_resp_data12", bus12.o_resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_clear_run("rstclr2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Initiator-side controller for the single-port accelerator SRAM (synchronous write, registered synchronous read). It accepts read/write requests from the BDD node-table logic over a valid/ready handshake and drives the SRAM address, write and data pins. It returns read data with a fixed two-cycle latency and runs a hardware clear sequence that zero-fills every location.

## Interface
Parameters:
- ADDR_WIDTH, 4, SRAM address width
- DATA_WIDTH, 32, data word width
- DEPTH, 16, number of valid locations; DEPTH <= 2**ADDR_WIDTH
- CLEAR_ON_RESET, 1, when 1 the block enters CLEAR automatically on reset release

Ports:
- i_clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid
- i_req_write  in  1  1 = write, 0 = read
- i_req_addr  in  ADDR_WIDTH  request address
- i_req_data  in  DATA_WIDTH  write data
- o_resp_valid  out  1  one-cycle pulse; read data valid
- o_resp_data  out  DATA_WIDTH  read data, held until next response
- i_clear  in  1  start a zero-fill, level-sampled in IDLE
- o_busy  out  1  high while in CLEAR
- o_clear_done  out  1  one-cycle pulse when zero-fill finishes
- o_mem_addr  out  ADDR_WIDTH  to SRAM address
- o_mem_write  out  1  to SRAM write enable
- o_mem_data  out  DATA_WIDTH  to SRAM write data
- i_mem_data  in  DATA_WIDTH  from SRAM registered read data

## Operation
- States: IDLE, CLEAR.
- Reset values: o_mem_addr=0, o_mem_write=0, o_mem_data=0, o_resp_valid=0, o_resp_data=0, o_clear_done=0, clear counter=0.
  - With CLEAR_ON_RESET=1: state=CLEAR and o_busy=1.
  - With CLEAR_ON_RESET=0: state=IDLE and o_busy=0.
  - Read pipeline valid bits are cleared.
- o_req_ready = (state==IDLE) && !i_clear. This is combinational and has no other dependency.
- Request accept (IDLE):
  - On the edge where valid && ready, register o_mem_addr=i_req_addr and o_mem_write=i_req_write. For writes also register o_mem_data=i_req_data.
  - Cycles with no accept drive o_mem_write=0. The address and data registers hold their values.
- Out-of-range addresses (i_req_addr >= DEPTH):
  - Writes are dropped; o_mem_write stays 0.
  - Reads complete normally with o_resp_valid, but o_resp_data=0.
- Reads are pipelined with one accept per cycle and no backpressure on responses. Responses return in request order. The consumer must take o_resp_valid when it is asserted.
- IDLE→CLEAR on any edge with i_clear=1. If i_req_valid is also high, the request is not accepted and the requester must hold it.
- CLEAR sequence:
  - Counter k runs 0..DEPTH-1, one location per cycle.
  - Drives o_mem_addr=k, o_mem_write=1, o_mem_data=0.
  - i_clear is ignored while in CLEAR.
- CLEAR→IDLE after the k=DEPTH-1 write. o_mem_write returns to 0, counter resets to 0, o_clear_done pulses for one cycle and o_busy drops in the same cycle.
- Reads already in flight when CLEAR starts complete with their pre-clear data.
- Reset asserted mid-operation: everything returns to reset values immediately, and any in-flight response is lost. With CLEAR_ON_RESET=1 the clear restarts from k=0.

## Timing
- Request accepted at edge N: SRAM pins are valid from N until N+1, and the SRAM samples at edge N+1.
- Read accepted at N: the SRAM registers data at N+1. The controller captures i_mem_data at N+2, and o_resp_valid=1 for the cycle after N+2. Latency is 2 edges.
- Write accepted at N: data is in the array after edge N+1. A read of the same address accepted at N+1 returns the new data.
- Back-to-back accepts: one per cycle with any read/write mix. Response count equals the read-accept count.
- CLEAR entered at edge E:
  - Location k is written at edge E+k+1.
  - The last write is presented in the cycle after E+DEPTH-1.
  - State is IDLE from edge E+DEPTH. o_clear_done is high during the cycle after E+DEPTH.
- Clear duration: exactly DEPTH cycles of o_busy=1.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16:
  - o_busy=1 and o_req_ready=0 for 16 cycles.
  - o_mem_addr steps 0..15 with o_mem_write=1 and o_mem_data=0.
  - o_clear_done pulses once, then o_req_ready=1.
- Write 0xDEADBEEF to addr 3, then read addr 3 on the next cycle → o_resp_valid exactly 2 edges after the read accept, o_resp_data=0xDEADBEEF.
- Back-to-back reads of addrs 1, 2, 3 (preloaded 0x11, 0x22, 0x33) → o_resp_valid high for 3 consecutive cycles with data 0x11, 0x22, 0x33 in order.
- Out-of-range access (ADDR_WIDTH=4, DEPTH=12):
  - Write to addr 14 → o_mem_write stays 0.
  - Read addr 14 → o_resp_valid with data 0.
- Issue a read of addr 5 (holding 0x55) and assert i_clear on the next edge:
  - The read returns 0x55.
  - The clear runs 16 cycles.
  - A subsequent read of addr 5 returns 0.
- Assert rst at clear step k=7 → outputs return to reset values asynchronously, and the clear restarts at addr 0 after rst falls.
